// File: rtl/dsram_pkg.sv
// dsram_pkg -- shared constants and types for the data SRAM slave.
//   SZ_*        : data_sram_size encodings (informational on the bus)
//   DELAY_DEF   : default extra response wait cycles
//   DEPTH_DEF   : default number of outstanding requests
//   ENTRY_W     : width of one response-queue entry {wr, rdata, countdown}
package dsram_pkg;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   localparam int DELAY_DEF = 2;
   localparam int DEPTH_DEF = 4;

   localparam int DATA_W  = 32;
   localparam int CNT_W   = 3;
   localparam int ENTRY_W = 1 + DATA_W + CNT_W;

   typedef struct packed {
      logic              wr;
      logic [DATA_W-1:0] rdata;
      logic [CNT_W-1:0]  cnt;
   } entry_t;

endpackage

// File: rtl/data_sram_slave_if.sv
// data_sram_slave_if -- request/response bus between a core and the data SRAM.
//   master drives: data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
//                  data_sram_addr, data_sram_wdata
//   slave drives : data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
interface data_sram_slave_if;
   import dsram_pkg::*;

   logic              data_sram_req;
   logic              data_sram_wr;
   logic [1:0]        data_sram_size;
   logic [3:0]        data_sram_wstrb;
   logic [31:0]       data_sram_addr;
   logic [DATA_W-1:0] data_sram_wdata;
   logic              data_sram_addr_ok;
   logic              data_sram_data_ok;
   logic [DATA_W-1:0] data_sram_rdata;

   modport master (
      output data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
             data_sram_addr, data_sram_wdata,
      input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
   );

   modport slave (
      input  data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
             data_sram_addr, data_sram_wdata,
      output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
   );
endinterface

// File: rtl/data_sram_ram.sv
// data_sram_ram -- single-port 2^AW x 32 store, synchronous read, byte write enables.
//   clk   : clock
//   en    : access this cycle (read always happens, write per lane)
//   we    : per-byte write enables
//   addr  : word address
//   wdata : write data
//   rdata : word at addr, registered one cycle after en
// Contents are deliberately not reset so they survive a slave reset.
module data_sram_ram
   import dsram_pkg::*;
#(
   parameter int AW = 12
) (
   input  logic              clk,
   input  logic              en,
   input  logic [3:0]        we,
   input  logic [AW-1:0]     addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_r [2**AW];

   // Storage array write and synchronous read port
   always_ff @(posedge clk) begin
      if (en) begin
         for (int b = 0; b < 4; b++) begin
            if (we[b]) begin
               mem_r[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
         end
         rdata <= mem_r[addr];
      end
   end

endmodule

// File: rtl/data_sram_slave.sv
// data_sram_slave -- pipelined SRAM slave answering every request after a fixed delay.
//   clk   : clock, all state on the rising edge
//   reset : synchronous active-high reset (store contents are kept)
//   bus   : data_sram_slave_if.slave request/response port
// Up to DEPTH accepted requests are tracked in a circular queue; each entry counts
// down from DELAY and retires (data_ok) when it reaches zero at the head.
module data_sram_slave
   import dsram_pkg::*;
#(
   parameter int DELAY = DELAY_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int AW    = 12
) (
   input  logic               clk,
   input  logic               reset,
   data_sram_slave_if.slave   bus
);

   localparam int             PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW-1:0]  LAST_PTR  = PW'(DEPTH - 1);
   localparam logic [3:0]     CNT_DEPTH = 4'(DEPTH);
   localparam logic [2:0]     DELAY_CNT = 3'(DELAY);

   entry_t            q_r [DEPTH];
   logic [DEPTH-1:0]  vld_r;
   logic [PW-1:0]     head_r;
   logic [PW-1:0]     tail_r;
   logic [3:0]        count_r;
   logic              cap_vld_r;
   logic [PW-1:0]     cap_idx_r;

   logic              addr_ok_s;
   logic              accept_s;
   logic              retire_s;
   logic [3:0]        ram_we_s;
   logic [DATA_W-1:0] ram_rdata_s;
   logic [DATA_W-1:0] rdata_s;
   logic              unused_s;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == LAST_PTR) ? PW'(0) : (p + PW'(1));
   endfunction

   // Size and the out-of-range / sub-word address bits carry no meaning here.
   assign unused_s = ^{bus.data_sram_size, bus.data_sram_addr[31:AW+2],
                       bus.data_sram_addr[1:0]};

   assign accept_s = bus.data_sram_req & addr_ok_s;
   assign ram_we_s = (accept_s && bus.data_sram_wr) ? bus.data_sram_wstrb : 4'h0;

   data_sram_ram #(.AW(AW)) u_ram (
      .clk   (clk),
      .en    (accept_s),
      .we    (ram_we_s),
      .addr  (bus.data_sram_addr[AW+1:2]),
      .wdata (bus.data_sram_wdata),
      .rdata (ram_rdata_s)
   );

   // Acceptance window, head retirement and response data selection
   always_comb begin
      addr_ok_s = 1'b0;
      retire_s  = 1'b0;
      rdata_s   = 32'h0;
      // Count only; a retire in the same cycle does not open the window.
      if (!reset && (count_r < CNT_DEPTH)) begin
         addr_ok_s = 1'b1;
      end else begin
         addr_ok_s = 1'b0;
      end
      if (!reset && vld_r[head_r] && (q_r[head_r].cnt == 3'd0)) begin
         retire_s = 1'b1;
      end else begin
         retire_s = 1'b0;
      end
      if (retire_s && !q_r[head_r].wr) begin
         // With DELAY=0 the load retires in the cycle its word is still on the
         // RAM output, before it has been captured into the entry.
         if (cap_vld_r && (cap_idx_r == head_r)) begin
            rdata_s = ram_rdata_s;
         end else begin
            rdata_s = q_r[head_r].rdata;
         end
      end else begin
         rdata_s = 32'h0;
      end
   end

   // Response queue: countdown, load-data capture, push on accept, pop on retire
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_r     <= '0;
         head_r    <= PW'(0);
         tail_r    <= PW'(0);
         count_r   <= 4'd0;
         cap_vld_r <= 1'b0;
         cap_idx_r <= PW'(0);
         for (int i = 0; i < DEPTH; i++) begin
            q_r[i].cnt <= 3'd0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (vld_r[i] && (q_r[i].cnt != 3'd0)) begin
               q_r[i].cnt <= q_r[i].cnt - 3'd1;
            end
         end
         if (cap_vld_r) begin
            q_r[cap_idx_r].rdata <= ram_rdata_s;
         end
         if (retire_s) begin
            vld_r[head_r] <= 1'b0;
            head_r        <= next_ptr(head_r);
         end
         if (accept_s) begin
            vld_r[tail_r] <= 1'b1;
            q_r[tail_r]   <= '{wr: bus.data_sram_wr, rdata: 32'h0, cnt: DELAY_CNT};
            tail_r        <= next_ptr(tail_r);
         end
         cap_vld_r <= accept_s & ~bus.data_sram_wr;
         cap_idx_r <= tail_r;
         case ({accept_s, retire_s})
            2'b10:   count_r <= count_r + 4'd1;
            2'b01:   count_r <= count_r - 4'd1;
            default: count_r <= count_r;
         endcase
      end
   end

   assign bus.data_sram_addr_ok = addr_ok_s;
   assign bus.data_sram_data_ok = retire_s;
   assign bus.data_sram_rdata   = rdata_s;

endmodule

// File: tb/tb_data_sram_slave.sv
// tb_data_sram_slave -- randomized scoreboard bench for data_sram_slave.
// Three instances with different DELAY/DEPTH share one clock. Each has a driver
// that keeps a word-array memory model and a list of due cycles, pushing the
// expected response on every accept, and a monitor that pops and compares on
// every data_ok.
module tb_data_sram_slave;
   import dsram_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;
   int done_cnt    = 0;

   localparam int NSTEPS = 700;

   typedef struct {
      int          due;
      logic [31:0] data;
   } exp_t;

   task automatic chk(input int inst, input string name,
                      input logic [31:0] act, input logic [31:0] want);
      vectors++;
      if (act !== want) begin
         miscompares++;
         $display("FAIL inst%0d %s: got %h want %h at %0t", inst, name, act, want, $time);
      end
   endtask

   for (genvar g = 0; g < 3; g++) begin : inst
      localparam int DL      = (g == 0) ? 2 : ((g == 1) ? 7 : 0);
      localparam int DP      = (g == 0) ? 4 : ((g == 1) ? 4 : 2);
      localparam int REQ_PCT = (g == 1) ? 90 : 70;

      data_sram_slave_if bus();
      logic reset_i = 1'b1;
      int   cyc = 0;
      exp_t expq[$];
      int   dues[$];
      logic [31:0] mem_m [4096];

      data_sram_slave #(.DELAY(DL), .DEPTH(DP), .AW(12)) dut (
         .clk   (clk),
         .reset (reset_i),
         .bus   (bus)
      );

      always @(posedge clk) cyc <= cyc + 1;

      // monitor: compare every response against the head of the expected queue
      always @(negedge clk) begin
         exp_t e;
         if (reset_i) begin
            chk(g, "reset_data_ok", {31'd0, bus.data_sram_data_ok}, 32'd0);
            chk(g, "reset_addr_ok", {31'd0, bus.data_sram_addr_ok}, 32'd0);
            chk(g, "reset_rdata", bus.data_sram_rdata, 32'd0);
         end else if (bus.data_sram_data_ok) begin
            if (expq.size() == 0) begin
               chk(g, "spurious_data_ok", {31'd0, bus.data_sram_data_ok}, 32'd0);
            end else begin
               e = expq.pop_front();
               chk(g, "resp_rdata", bus.data_sram_rdata, e.data);
               chk(g, "resp_cycle", cyc, e.due);
            end
         end else begin
            chk(g, "idle_rdata", bus.data_sram_rdata, 32'd0);
         end
      end

      // driver and reference model
      initial begin
         int          dir;
         logic        have_op, op_wr, exp_ok;
         logic [11:0] op_idx;
         logic [3:0]  op_wstrb;
         logic [31:0] op_wdata, op_addr, w;
         logic [1:0]  op_size;
         logic [11:0] idx_tab [8];
         idx_tab = '{12'h400, 12'h001, 12'h002, 12'h003, 12'hFFF, 12'h07F, 12'h200, 12'h555};
         bus.data_sram_req   = 1'b0;
         bus.data_sram_wr    = 1'b0;
         bus.data_sram_size  = 2'd0;
         bus.data_sram_wstrb = 4'h0;
         bus.data_sram_addr  = 32'h0;
         bus.data_sram_wdata = 32'h0;
         have_op = 1'b0; op_wr = 1'b0; op_idx = 12'h0; op_wstrb = 4'h0;
         op_wdata = 32'h0; op_addr = 32'h0; op_size = 2'd0;
         dir = 0;
         repeat (3) @(negedge clk);
         for (int step = 0; step < NSTEPS; step++) begin
            @(negedge clk); #1;
            while (dues.size() > 0 && dues[0] < cyc) void'(dues.pop_front());
            exp_ok = !reset_i && (dues.size() < DP);
            chk(g, "addr_ok", {31'd0, bus.data_sram_addr_ok}, {31'd0, exp_ok});
            if (reset_i) begin
               reset_i = 1'b0;
            end else if (step > 40 && $urandom_range(0, 99) < 2) begin
               reset_i = 1'b1;
               bus.data_sram_req = 1'b0;
               dues.delete();
               expq.delete();
               continue;
            end
            if (!have_op) begin
               if (dir < 15) begin
                  have_op  = 1'b1;
                  op_wr    = 1'b1;
                  op_wstrb = 4'hF;
                  op_wdata = $urandom;
                  op_idx   = idx_tab[dir % 8];
                  case (dir)
                     8:  op_wdata = 32'hDEADBEEF;
                     9:  op_wr = 1'b0;
                     10: begin op_wstrb = 4'b0100; op_wdata = 32'h00AA0000; end
                     11: op_wr = 1'b0;
                     12, 13, 14: begin op_wr = 1'b0; op_idx = idx_tab[dir - 11]; end
                     default: ;
                  endcase
                  op_addr = {18'd0, op_idx, 2'b00};
                  op_size = SZ_WORD;
                  dir++;
               end else if ($urandom_range(0, 99) < REQ_PCT) begin
                  have_op  = 1'b1;
                  op_wr    = 1'($urandom_range(0, 1));
                  op_idx   = idx_tab[$urandom_range(0, 7)];
                  op_wstrb = 4'($urandom);
                  op_wdata = $urandom;
                  op_size  = 2'($urandom_range(0, 2));
                  op_addr  = {18'($urandom), op_idx, 2'($urandom)};
               end
            end
            bus.data_sram_req   = have_op;
            bus.data_sram_wr    = op_wr;
            bus.data_sram_size  = op_size;
            bus.data_sram_wstrb = op_wstrb;
            bus.data_sram_addr  = op_addr;
            bus.data_sram_wdata = op_wdata;
            if (have_op && dues.size() < DP) begin
               if (op_wr) begin
                  w = mem_m[op_idx];
                  for (int b = 0; b < 4; b++)
                     if (op_wstrb[b]) w[8*b +: 8] = op_wdata[8*b +: 8];
                  mem_m[op_idx] = w;
                  expq.push_back('{cyc + 1 + DL, 32'h0});
               end else begin
                  expq.push_back('{cyc + 1 + DL, mem_m[op_idx]});
               end
               dues.push_back(cyc + 1 + DL);
               have_op = 1'b0;
            end
         end
         @(negedge clk); #1;
         bus.data_sram_req = 1'b0;
         reset_i = 1'b0;
         repeat (DL + 6) @(negedge clk);
         #1;
         chk(g, "drain_pending", expq.size(), 32'd0);
         done_cnt++;
      end
   end

   initial begin
      for (int i = 0; i < 30000 && done_cnt < 3; i++) @(posedge clk);
      if (done_cnt < 3) begin
         miscompares++;
         $display("FAIL timeout: finished instances %0d want 3", done_cnt);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
